instr_register_reader: RTL

//  Hardware read-back engine at the read port of instr_register. On start, walks read_pointer

---
 rtl/instr_register_pkg.sv | 67 ++++++
 rtl/instr_reader_fifo.sv | 56 +++++
 rtl/instr_register_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared instruction/result types for instr_register and its hardware read-back engine,
// including the record format streamed by instr_register_reader and the reference ALU function.
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] rezultat_t;

    typedef struct packed {
        opcode_t   opc;
        operand_t  op_a;
        operand_t  op_b;
        rezultat_t op_r;
    } instruction_t;

    localparam int unsigned REC_ADDR_W = 5;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        instruction_t          iw;
        rezultat_t             result;
        logic                  div_zero;
    } rd_record_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    function automatic logic is_div_zero(instruction_t iw);
        return ((iw.opc == DIV) || (iw.opc == MOD)) && (iw.op_b == '0);
    endfunction

    // Operands are widened to the full result width first so MULT and DIV never overflow.
    function automatic rezultat_t calc_result(instruction_t iw);
        rezultat_t a;
        rezultat_t b;
        rezultat_t r;
        a = {{32{iw.op_a[31]}}, iw.op_a};
        b = {{32{iw.op_b[31]}}, iw.op_b};
        r = '0;
        case (iw.opc)
            ZERO:    r = '0;
            PASSA:   r = a;
            PASSB:   r = b;
            ADD:     r = a + b;
            SUB:     r = a - b;
            MULT:    r = a * b;
            DIV:     if (b != '0) r = a / b;
            MOD:     if (b != '0) r = a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_reader_fifo.sv
// Small synchronous FIFO of read-back records; head is shown combinationally on dout.
// A push into a full FIFO is accepted only together with a pop.
module instr_reader_fifo
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  rd_record_t       din,
    input  logic             pop,
    output rd_record_t       dout,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    rd_record_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_register_reader.sv
// Read-back engine for instr_register: walks read_pointer over a block, recomputes results and
// streams records on a valid/ready port. Optional RESULT_CHECK_EN adds op_r comparison outputs.
module instr_register_reader
    import instr_register_pkg::*;
#(
    parameter int unsigned ADDR_W     = REC_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] read_pointer,
    input  instruction_t      instruction_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output instruction_t      out_iw,
    output rezultat_t         out_result,
    output logic              out_div_zero,
`ifdef RESULT_CHECK_EN
    output logic              out_mismatch,
    output logic [15:0]       error_count,
`endif
    output logic              busy,
    output logic              done
);
    // state | meaning: RD_IDLE wait for start | RD_ISSUE read locations | RD_DRAIN empty pipeline
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              done_q;
    logic              s1_valid_q;
    instruction_t      s1_iw_q;
    logic [ADDR_W-1:0] s1_addr_q;

    logic [CNT_W-1:0]  fifo_count;
    rd_record_t        push_rec;
    rd_record_t        head_rec;
    logic              pop;
    logic              issue;
    logic              drain_done;
    logic [CNT_W:0]    occupancy;

    assign pop = out_valid && out_ready;

    // Records already queued plus the one in stage 1 must leave room for the next issue.
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q} - {{CNT_W{1'b0}}, pop};
    assign issue      = (state_q == RD_ISSUE) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign drain_done = (state_q == RD_DRAIN) && !s1_valid_q
                        && (fifo_count == {{(CNT_W-1){1'b0}}, pop});

    always_comb begin
        push_rec          = '0;
        push_rec.addr     = s1_addr_q;
        push_rec.iw       = s1_iw_q;
        push_rec.result   = calc_result(s1_iw_q);
        push_rec.div_zero = is_div_zero(s1_iw_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RD_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_iw_q    <= '0;
            s1_addr_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            s1_valid_q <= issue;
            if (issue) begin
                s1_iw_q   <= instruction_word;
                s1_addr_q <= addr_q;
            end
            case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= start_addr;
                            remain_q <= count;
                            state_q  <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (issue) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        remain_q <= remain_q - (ADDR_W+1)'(1);
                        if (remain_q == (ADDR_W+1)'(1)) begin
                            state_q <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (drain_done) begin
                        state_q <= RD_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    instr_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (s1_valid_q),
        .din     (push_rec),
        .pop     (pop),
        .dout    (head_rec),
        .count   (fifo_count)
    );

    assign read_pointer = addr_q;
    assign out_valid    = (fifo_count != '0);
    assign out_addr     = head_rec.addr;
    assign out_iw       = head_rec.iw;
    assign out_result   = head_rec.result;
    assign out_div_zero = head_rec.div_zero;
    assign busy         = (state_q != RD_IDLE);
    assign done         = done_q;

`ifdef RESULT_CHECK_EN
    logic [15:0] err_q;

    assign out_mismatch = out_valid && (head_rec.iw.op_r != head_rec.result);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if ((state_q == RD_IDLE) && start) begin
            err_q <= '0;
        end else if (pop && out_mismatch && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign error_count = err_q;
`endif

endmodule
